// File: rtl/dram_responder_if.sv
// dram_responder_if
//   Request/data bundle between an address unit (master) and the
//   dram_responder storage model (slave).
//
//   addr   [15:0]  burst start word address (master -> slave)
//   req            request strobe, honoured only while busy=0
//   we             1 = write burst, 0 = read burst
//   len    [3:0]   beats minus one
//   wdata  [15:0]  write data, consumed on edges where wready=1
//   rdata  [15:0]  read data, meaningful while rvalid=1
//   rvalid         one read beat per cycle while high
//   wready         slave consumes wdata at the end of this cycle
//   busy           slave is not idle; new requests are dropped
interface dram_responder_if;
  logic [15:0] addr;
  logic        req;
  logic        we;
  logic [3:0]  len;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        wready;
  logic        busy;

  modport master (
    output addr, req, we, len, wdata,
    input  rdata, rvalid, wready, busy
  );

  modport slave (
    input  addr, req, we, len, wdata,
    output rdata, rvalid, wready, busy
  );
endinterface

// File: rtl/dram_responder.sv
// dram_responder
//   Behavioural DRAM-like burst responder. A request accepted in IDLE waits
//   LATENCY cycles, then streams len+1 beats of read data (one per cycle,
//   registered) or consumes len+1 beats of write data. Word index for beat
//   b is (addr[AW-1:0] + b) mod 2**AW, so bursts wrap around the top.
//
//   Parameters
//     AW       low address bits used to index storage (2**AW words)
//     LATENCY  wait cycles between acceptance and first beat (0..15)
//
//   Ports
//     Clk1     clock, all state changes on its rising edge
//     Rst      asynchronous active-high reset (storage is not cleared)
//     bus      dram_responder_if.slave request/data bundle
module dram_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic              Clk1,
  input  logic              Rst,
  dram_responder_if.slave   bus
);

  localparam int DEPTH = 1 << AW;

  // WAIT counts down from LATENCY-1 to 0; unused when LATENCY=0.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RBURST = 2'd2,
    WBURST = 2'd3
  } state_t;

  // Beat offset added to the start index, wrapping modulo 2**AW.
  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] base,
                                             input logic [3:0]    off);
    return base + AW'(off);
  endfunction

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, wait_cnt_nxt;
  logic [3:0]      beat, beat_nxt;
  logic [AW-1:0]   start_addr, start_nxt;
  logic            burst_we, we_nxt;
  logic [3:0]      burst_len, len_nxt;
  logic [15:0]     rdata_q;

  logic            rd_load;
  logic [AW-1:0]   rd_idx;
  logic            mem_wr;
  logic [AW-1:0]   wr_idx;

  logic [15:0]     mem [DEPTH];

  // Address bits above the storage index are deliberately ignored.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[15:AW];

  // Next-state / datapath control.
  // rdata is registered, so the word for the next read beat is selected
  // on the edge that enters (or advances within) RBURST.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    beat_nxt     = beat;
    start_nxt    = start_addr;
    we_nxt       = burst_we;
    len_nxt      = burst_len;
    rd_load      = 1'b0;
    rd_idx       = start_addr;
    mem_wr       = 1'b0;
    wr_idx       = wrap_idx(start_addr, beat);

    unique case (state)
      IDLE: begin
        if (bus.req) begin
          start_nxt = bus.addr[AW-1:0];
          we_nxt    = bus.we;
          len_nxt   = bus.len;
          beat_nxt  = 4'd0;
          if (LATENCY == 0) begin
            state_nxt = bus.we ? WBURST : RBURST;
            rd_load   = ~bus.we;
            rd_idx    = bus.addr[AW-1:0];
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end

      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = burst_we ? WBURST : RBURST;
          rd_load   = ~burst_we;
          rd_idx    = start_addr;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end

      RBURST: begin
        if (beat == burst_len) begin
          state_nxt = IDLE;
          beat_nxt  = 4'd0;
        end else begin
          beat_nxt = beat + 4'd1;
          rd_load  = 1'b1;
          rd_idx   = wrap_idx(start_addr, beat + 4'd1);
        end
      end

      WBURST: begin
        mem_wr = 1'b1;
        if (beat == burst_len) begin
          state_nxt = IDLE;
          beat_nxt  = 4'd0;
        end else begin
          beat_nxt = beat + 4'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any burst in flight.
  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      beat       <= 4'd0;
      start_addr <= '0;
      burst_we   <= 1'b0;
      burst_len  <= 4'd0;
      rdata_q    <= 16'd0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      beat       <= beat_nxt;
      start_addr <= start_nxt;
      burst_we   <= we_nxt;
      burst_len  <= len_nxt;
      if (rd_load) begin
        rdata_q <= mem[rd_idx];
      end
    end
  end

  // Storage survives reset. Reset forces IDLE asynchronously, so no write
  // can happen on an edge while Rst is high.
  always_ff @(posedge Clk1) begin
    if (mem_wr) begin
      mem[wr_idx] <= bus.wdata;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.rvalid = (state == RBURST);
  assign bus.wready = (state == WBURST);
  assign bus.rdata  = rdata_q;

  beat_bound: assert property (@(posedge Clk1) disable iff (Rst)
    beat <= burst_len);

  rw_exclusive: assert property (@(posedge Clk1) disable iff (Rst)
    !(bus.rvalid && bus.wready));

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder
//   Directed bench for dram_responder. Main instance uses LATENCY=2 and is
//   checked every cycle against a timing/memory model derived from burst
//   arithmetic (acceptance edge, wait length, beat index). A second
//   instance with LATENCY=0 is exercised with literal expectations.
module tb_dram_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dram_responder_if bus ();
  dram_responder_if bus0 ();

  dram_responder #(.AW(8), .LATENCY(LAT)) dut (
    .Clk1 (clk),
    .Rst  (rst),
    .bus  (bus)
  );

  dram_responder #(.AW(8), .LATENCY(0)) dut0 (
    .Clk1 (clk),
    .Rst  (rst),
    .bus  (bus0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          cyc = 0;        // number of rising edges seen
  bit          m_act = 1'b0;
  int          m_n0, m_start, m_len, m_b;
  bit          m_we;
  bit          m_was;
  logic [15:0] mm [256];
  logic        exp_busy = 1'b0, exp_rv = 1'b0, exp_wr = 1'b0;
  logic [15:0] exp_rdata = 16'd0;

  // Burst accepted at edge n0: beat b occupies the cycle after edge
  // n0+LAT+b and completes on edge n0+LAT+b+1.
  task automatic model_step();
    cyc++;
    if (rst) begin
      m_act = 1'b0;
      exp_busy = 1'b0; exp_rv = 1'b0; exp_wr = 1'b0; exp_rdata = 16'd0;
    end else begin
      m_was = m_act;
      if (m_act) begin
        m_b = cyc - m_n0 - LAT - 1;
        if (m_b >= 0 && m_we) mm[(m_start + m_b) % 256] = bus.wdata;
        if (m_b == m_len) m_act = 1'b0;
      end
      if (!m_was && bus.req === 1'b1) begin
        m_act = 1'b1; m_n0 = cyc; m_start = int'(bus.addr[7:0]);
        m_we = bus.we; m_len = int'(bus.len);
      end
      if (m_act) begin
        m_b = cyc - m_n0 - LAT;
        exp_busy = 1'b1;
        exp_rv = (!m_we && m_b >= 0);
        exp_wr = (m_we && m_b >= 0);
        if (exp_rv) exp_rdata = mm[(m_start + m_b) % 256];
      end else begin
        exp_busy = 1'b0; exp_rv = 1'b0; exp_wr = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("busy",   {15'd0, bus.busy},   {15'd0, exp_busy});
    chk("rvalid", {15'd0, bus.rvalid}, {15'd0, exp_rv});
    chk("wready", {15'd0, bus.wready}, {15'd0, exp_wr});
    chk("rdata",  bus.rdata, exp_rdata);
  end

  // ---------------- write feeder / read monitor ----------------
  logic [15:0] wq [$];
  logic [15:0] rd_log [$];
  int          first_rv, last_rv, acc_edge;

  initial forever begin
    @(negedge clk);
    if (bus.wready === 1'b1 && wq.size() > 0) bus.wdata = wq.pop_front();
    if (bus.rvalid === 1'b1) begin
      if (rd_log.size() == 0) first_rv = cyc;
      last_rv = cyc;
      rd_log.push_back(bus.rdata);
    end
  end

  task automatic burst(input bit w, input logic [15:0] a, input logic [3:0] l,
                       input int collide_at);
    int n;
    rd_log.delete();
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.len = l;
    acc_edge = cyc + 1;
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
      if (n == collide_at && bus.busy === 1'b1) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0080; bus.len = 4'd7;
      end else begin
        bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    chk("burst_done", {15'd0, bus.busy}, 16'd0);
  endtask

  task automatic read_one(input logic [15:0] a, input logic [15:0] exp, input string name);
    burst(1'b0, a, 4'd0, -1);
    chk({name, "_cnt"}, 16'(rd_log.size()), 16'd1);
    if (rd_log.size() > 0) chk(name, rd_log[0], exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'd0; bus.len = 4'd0; bus.wdata = 16'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 16'd0; bus0.len = 4'd0; bus0.wdata = 16'd0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy",   {15'd0, bus.busy},   16'd0);
    chk("rst_rvalid", {15'd0, bus.rvalid}, 16'd0);
    chk("rst_rdata",  bus.rdata,           16'd0);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=0 instance: single-beat write, then single-beat read.
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 16'h0005; bus0.len = 4'd0;
    bus0.wdata = 16'h5A5A;
    @(negedge clk);
    chk("l0_wready_on", {15'd0, bus0.wready}, 16'd1);
    chk("l0_busy_on",   {15'd0, bus0.busy},   16'd1);
    bus0.req = 1'b0;
    @(negedge clk);
    chk("l0_wready_off", {15'd0, bus0.wready}, 16'd0);
    chk("l0_busy_off",   {15'd0, bus0.busy},   16'd0);
    bus0.req = 1'b1; bus0.we = 1'b0;
    @(negedge clk);
    chk("l0_rvalid_on", {15'd0, bus0.rvalid}, 16'd1);
    chk("l0_rdata",     bus0.rdata,           16'h5A5A);
    bus0.req = 1'b0;
    @(negedge clk);
    chk("l0_rvalid_off", {15'd0, bus0.rvalid}, 16'd0);
    chk("l0_busy_idle",  {15'd0, bus0.busy},   16'd0);
    chk("l0_rdata_hold", bus0.rdata,           16'h5A5A);

    // Write then read back with latency measurement.
    wq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    burst(1'b1, 16'h0010, 4'd3, -1);
    chk("model_pin_10", mm[8'h10], 16'h00A0);
    chk("model_pin_13", mm[8'h13], 16'h00A3);
    burst(1'b0, 16'h0010, 4'd3, -1);
    chk("wr_rd_cnt", 16'(rd_log.size()), 16'd4);
    if (rd_log.size() == 4) begin
      chk("wr_rd_b0", rd_log[0], 16'h00A0);
      chk("wr_rd_b1", rd_log[1], 16'h00A1);
      chk("wr_rd_b2", rd_log[2], 16'h00A2);
      chk("wr_rd_b3", rd_log[3], 16'h00A3);
    end
    chk("first_beat_delay", 16'(first_rv - acc_edge + 1), 16'd3);

    // Wrap across the top of storage; upper address bits ignored.
    wq = '{16'h1111, 16'h2222};
    burst(1'b1, 16'h00FF, 4'd1, -1);
    read_one(16'h00FF, 16'h1111, "wrap_ff");
    read_one(16'h0000, 16'h2222, "wrap_00");
    read_one(16'h01FF, 16'h1111, "alias_1ff");
    burst(1'b0, 16'h00FF, 4'd1, -1);
    chk("wrap_rd_cnt", 16'(rd_log.size()), 16'd2);
    if (rd_log.size() == 2) chk("wrap_rd_b1", rd_log[1], 16'h2222);

    // Maximum burst length.
    for (int i = 0; i < 16; i++) wq.push_back(16'h3000 + 16'(i));
    burst(1'b1, 16'h0020, 4'd15, -1);
    burst(1'b0, 16'h0020, 4'd15, -1);
    chk("max_cnt", 16'(rd_log.size()), 16'd16);
    chk("max_span", 16'(last_rv - first_rv), 16'd15);
    if (rd_log.size() == 16) begin
      chk("max_b0",  rd_log[0],  16'h3000);
      chk("max_b15", rd_log[15], 16'h300F);
    end

    // Request pulse during an active burst is dropped.
    burst(1'b0, 16'h0020, 4'd3, 2);
    chk("collide_cnt", 16'(rd_log.size()), 16'd4);
    if (rd_log.size() == 4) chk("collide_b3", rd_log[3], 16'h3003);

    // Reset during beat 2 of a write burst.
    wq = '{16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03};
    burst(1'b1, 16'h0040, 4'd3, -1);
    wq = '{16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3};
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0040; bus.len = 4'd3;
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (bus.wready === 1'b1) k++;
    end
    chk("abort_reached_beat2", 16'(k), 16'd3);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   {15'd0, bus.busy},   16'd0);
    chk("abort_wready", {15'd0, bus.wready}, 16'd0);
    chk("abort_rvalid", {15'd0, bus.rvalid}, 16'd0);
    chk("abort_rdata",  bus.rdata,           16'd0);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    chk("model_pin_42", mm[8'h42], 16'h0B02);
    burst(1'b0, 16'h0040, 4'd3, -1);
    chk("abort_rd_cnt", 16'(rd_log.size()), 16'd4);
    if (rd_log.size() == 4) begin
      chk("abort_b0", rd_log[0], 16'h00C0);
      chk("abort_b1", rd_log[1], 16'h00C1);
      chk("abort_b2", rd_log[2], 16'h0B02);
      chk("abort_b3", rd_log[3], 16'h0B03);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Parameters
REQ-001 The block SHALL have parameter AW, default 8: number of low address bits used to index storage (2**AW words).
REQ-002 The block SHALL have parameter LATENCY, default 2: wait cycles between request acceptance and the first data beat; legal range 0..15.

Interface
REQ-003 Clk1  input  1  single clock; all state SHALL change on posedge Clk1.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 addr  input  16  burst start word address, driven by the address unit.
REQ-006 req  input  1  request strobe; SHALL be sampled only while busy=0.
REQ-007 we  input  1  1 = write burst, 0 = read burst; sampled with req.
REQ-008 len  input  4  beat count minus 1 (0 = 1 beat, 15 = 16 beats); sampled with req.
REQ-009 wdata  input  16  write data; SHALL be sampled on each edge where wready=1.
REQ-010 rdata  output  16  read data; SHALL be valid only while rvalid=1.
REQ-011 rvalid  output  1  one read beat presented per cycle while high.
REQ-012 wready  output  1  responder consumes wdata at the end of this cycle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Storage SHALL be 2**AW x 16-bit words, indexed by (addr[AW-1:0] + beat) mod 2**AW; addr bits above AW-1 SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, WAIT, RBURST and WBURST.
REQ-016 In IDLE with req=1: the block SHALL latch addr[AW-1:0], we and len, clear the beat counter, and go to WAIT (LATENCY>0) or directly to RBURST/WBURST (LATENCY=0).
REQ-017 In IDLE with req=0: the block SHALL stay in IDLE.
REQ-018 WAIT SHALL last exactly LATENCY cycles via a down-counter loaded with LATENCY-1, then go to RBURST if we=0, else WBURST.
REQ-019 Latency SHALL be LATENCY+1 cycles from the accepting edge to the edge ending the first beat; the first beat SHALL be visible LATENCY+1 cycles after the req=1 sample.
REQ-020 RBURST: rvalid=1 and rdata=mem[start+beat] (registered), one beat per cycle, no stalls, len+1 consecutive beats.
REQ-021 WBURST: wready=1 for len+1 consecutive cycles; each edge SHALL write wdata to mem[start+beat].
REQ-022 After the last beat (beat==len), the block SHALL return to IDLE; busy SHALL drop the cycle after the last beat.
REQ-023 req asserted while busy=1 SHALL be ignored and not queued; the requester must hold or reissue it.
REQ-024 Outside RBURST, rvalid SHALL be 0 and rdata SHALL hold its last value. Outside WBURST, wready SHALL be 0.
REQ-025 Address wrap: a burst crossing 2**AW-1 SHALL continue at index 0.
REQ-026 The beat counter SHALL be 4 bits and never exceed len.

Reset
REQ-027 Rst=1 SHALL immediately force IDLE, busy=0, rvalid=0, wready=0, rdata=0, and clear the counters and latched request, including mid-burst.
REQ-028 Memory contents SHALL NOT be reset; words written before Rst SHALL be retained.
REQ-029 A burst aborted by Rst SHALL leave already-written beats in memory; remaining beats SHALL NOT be written.

Verification
REQ-030 Write then read: req=1, we=1, addr=0x0010, len=3, data 0xA0..0xA3, then a read of the same range -> rdata 0xA0,0xA1,0xA2,0xA3 on 4 consecutive rvalid cycles, first rvalid 3 cycles after the req sample (LATENCY=2).
REQ-031 Wrap: write len=1 at addr=0x00FF with 0x1111, 0x2222 -> reads of 0x00FF=0x1111 and 0x0000=0x2222; a read at addr=0x01FF also returns 0x1111.
REQ-032 Busy collision: a second req pulse during an active burst -> no extra beats and busy=0 after len+1 beats.
REQ-033 Reset mid-write: Rst during beat 2 of a len=3 write -> all outputs 0 immediately; a later read shows beats 0-1 written and beats 2-3 holding their old values.
REQ-034 LATENCY=0 build: read len=0 -> rvalid high exactly one cycle, on the cycle after the req sample.
REQ-035 Max burst: len=15 read -> exactly 16 rvalid cycles, no gaps, then busy=0.
